// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control unit:
// FSM state encoding, default operand width and control-strobe bit positions.
package booth_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    TEST,
    ADD,
    SUB,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } state_t;

  // Bit positions inside the internal strobe vector; c<k> == strobe[k].
  localparam int unsigned C_LOADM     = 0;
  localparam int unsigned C_LOADQ     = 1;
  localparam int unsigned C_ADD       = 2;
  localparam int unsigned C_SUB       = 3;
  localparam int unsigned C_SHIFT     = 4;
  localparam int unsigned C_OUTA      = 5;
  localparam int unsigned C_OUTQ      = 6;
  localparam int unsigned NUM_STROBES = 7;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared at operand load, stepped once per shift,
// flags the final iteration and wraps back to zero after it.
module booth_iter_cnt #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/booth_ctrl.sv
// Moore FSM sequencing the one-hot datapath strobes c0..c6 of a radix-2
// Booth multiplier; all outputs decode from the state register only.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  state_t                 state_q;
  state_t                 state_d;
  logic [NUM_STROBES-1:0] strobe;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   cnt_last;

  booth_iter_cnt #(
    .N  (N),
    .CW (CW)
  ) u_iter_cnt (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    strobe  = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
      end
      LOAD_M: begin
        strobe[C_LOADM] = 1'b1;
        cnt_clr         = 1'b1;
        state_d         = LOAD_Q;
      end
      LOAD_Q: begin
        strobe[C_LOADQ] = 1'b1;
        state_d         = TEST;
      end
      TEST: begin
        // Booth recoding of {Q[0], Q[-1]}: 01 adds M, 10 subtracts M.
        case ({q0, q_m1})
          2'b01:   state_d = ADD;
          2'b10:   state_d = SUB;
          default: state_d = SHIFT;
        endcase
      end
      ADD: begin
        strobe[C_ADD] = 1'b1;
        state_d       = SHIFT;
      end
      SUB: begin
        strobe[C_SUB] = 1'b1;
        state_d       = SHIFT;
      end
      SHIFT: begin
        strobe[C_SHIFT] = 1'b1;
        cnt_inc         = 1'b1;
        state_d         = cnt_last ? OUT_A : TEST;
      end
      OUT_A: begin
        strobe[C_OUTA] = 1'b1;
        state_d        = OUT_Q;
      end
      OUT_Q: begin
        strobe[C_OUTQ] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign c0 = strobe[C_LOADM];
  assign c1 = strobe[C_LOADQ];
  assign c2 = strobe[C_ADD];
  assign c3 = strobe[C_SUB];
  assign c4 = strobe[C_SHIFT];
  assign c5 = strobe[C_OUTA];
  assign c6 = strobe[C_OUTQ];

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a behavioural A/Q/M datapath answers the strobes, and a
// per-cycle expected {busy,done,c6..c0} queue is built from the multiplier bits.
module tb_booth_ctrl;

  localparam logic [8:0] E_IDLE  = 9'b0_0_0000000;
  localparam logic [8:0] E_LOADM = 9'b1_0_0000001;
  localparam logic [8:0] E_LOADQ = 9'b1_0_0000010;
  localparam logic [8:0] E_TEST  = 9'b1_0_0000000;
  localparam logic [8:0] E_ADD   = 9'b1_0_0000100;
  localparam logic [8:0] E_SUB   = 9'b1_0_0001000;
  localparam logic [8:0] E_SHIFT = 9'b1_0_0010000;
  localparam logic [8:0] E_OUTA  = 9'b1_0_0100000;
  localparam logic [8:0] E_OUTQ  = 9'b1_0_1000000;
  localparam logic [8:0] E_DONE  = 9'b1_1_0000000;

  logic clk = 1'b0;
  logic rst_b;
  logic start;
  logic c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [7:0] reg_a, reg_q, reg_m;
  logic       reg_qm1;
  logic [7:0] dp_mc, dp_mp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .q0    (reg_q[0]),
    .q_m1  (reg_qm1),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .c5    (c5),
    .c6    (c6),
    .busy  (busy),
    .done  (done)
  );

  // Behavioural datapath responding to the strobes.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      reg_a <= '0; reg_q <= '0; reg_m <= '0; reg_qm1 <= 1'b0;
    end else begin
      if (c0) begin reg_m <= dp_mc; reg_a <= '0; reg_qm1 <= 1'b0; end
      if (c1) reg_q <= dp_mp;
      if (c2) reg_a <= reg_a + reg_m;
      if (c3) reg_a <= reg_a - reg_m;
      if (c4) {reg_a, reg_q, reg_qm1} <= {reg_a[7], reg_a, reg_q};
    end
  end

  function automatic logic [8:0] observed();
    return {busy, done, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      n_cmp++;
      assert ($countones({c6, c5, c4, c3, c2, c1, c0}) <= 1) else begin
        n_bad++;
        $error("FAIL onehot observed=%b expected=at_most_one", {c6, c5, c4, c3, c2, c1, c0});
      end
    end
  end

  // abort_shift>0: assert reset during that SHIFT. chain: start already high from
  // the previous run. poke: pulse start in first TEST and hold it from OUT_Q on.
  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp,
                        input int abort_shift, input bit chain, input bit poke);
    logic [8:0] exq[$];
    logic [8:0] e;
    logic signed [15:0] prod;
    bit prev, aborted, pulse_pending, poked;
    int ops_n, shifts, busy_n;
    dp_mc = mc;
    dp_mp = mp;
    exq.push_back(E_LOADM);
    exq.push_back(E_LOADQ);
    prev = 1'b0;
    ops_n = 0;
    for (int i = 0; i < 8; i++) begin
      exq.push_back(E_TEST);
      if (mp[i] && !prev) begin exq.push_back(E_SUB); ops_n++; end
      else if (!mp[i] && prev) begin exq.push_back(E_ADD); ops_n++; end
      exq.push_back(E_SHIFT);
      prev = mp[i];
    end
    exq.push_back(E_OUTA);
    exq.push_back(E_OUTQ);
    exq.push_back(E_DONE);
    exq.push_back(E_IDLE);
    if (!chain) start = 1'b1;
    shifts = 0; busy_n = 0; aborted = 0; pulse_pending = 0; poked = 0;
    while (exq.size() > 0 && !aborted) begin
      @(negedge clk);
      e = exq.pop_front();
      check("seq", {7'b0, observed()}, {7'b0, e});
      busy_n += int'(busy);
      if (e == E_LOADM) start = 1'b0;
      if (pulse_pending) begin start = 1'b0; pulse_pending = 0; end
      if (poke && e == E_TEST && !poked) begin start = 1'b1; pulse_pending = 1; poked = 1; end
      if (poke && e == E_OUTQ) start = 1'b1;
      if (e == E_SHIFT) begin
        shifts++;
        if (abort_shift != 0 && shifts == abort_shift) begin
          #2 rst_b = 1'b0;
          #1 check("rst_async", {7'b0, observed()}, {7'b0, E_IDLE});
          aborted = 1;
        end
      end
    end
    if (!aborted) begin
      check("busy_cycles", 16'(busy_n), 16'(5 + 16 + ops_n));
      prod = $signed({{8{mc[7]}}, mc}) * $signed({{8{mp[7]}}, mp});
      check("product", {reg_a, reg_q}, prod);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    dp_mc = '0;
    dp_mp = '0;
    #1 check("reset_state", {7'b0, observed()}, {7'b0, E_IDLE});
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {7'b0, observed()}, {7'b0, E_IDLE});

    run_op(8'h13, 8'h00, 0, 0, 0);
    run_op(8'h13, 8'h01, 0, 0, 0);
    run_op(8'hF3, 8'h55, 0, 0, 0);
    run_op(8'h25, 8'hFF, 0, 0, 0);

    run_op(8'h13, 8'h00, 4, 0, 0);
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("held_in_reset", {7'b0, observed()}, {7'b0, E_IDLE});
    end
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_post_abort", {7'b0, observed()}, {7'b0, E_IDLE});
    end
    run_op(8'h7F, 8'h81, 0, 0, 0);

    run_op(8'hE9, 8'h55, 0, 0, 1);
    run_op(8'h31, 8'h01, 0, 1, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Control unit for the radix-2 Booth multiplier datapath. It sequences the one-hot control strobes `c0`..`c6` that drive the M, A and Q registers. It inspects the multiplier bit pair Q[0]/Q[-1] each iteration and signals completion to the host. It is the initiator side of the strobe interface that the datapath registers respond to.

## Interface
- `N`, default 8: operand width; equals the number of Booth iterations.
- `CW`, default `$clog2(N)`: iteration counter width.

- `clk`  in  1: clock.
- `rst_b`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiplication; sampled only in IDLE.
- `q0`  in  1: current Q[0] from the Q register.
- `q_m1`  in  1: Q[-1], the bit last shifted out of Q.
- `c0`  out  1: load M from ibus; clear A and Q[-1].
- `c1`  out  1: load Q from ibus.
- `c2`  out  1: A <= A + M.
- `c3`  out  1: A <= A − M.
- `c4`  out  1: arithmetic shift right A:Q:Q[-1]; A[0] enters Q[N-1].
- `c5`  out  1: drive A onto obus (high product half).
- `c6`  out  1: drive Q onto obus (low product half).
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse in DONE.

## Operation
- Moore FSM. All outputs decode from the state register only; none depend combinationally on `start`, `q0` or `q_m1`.
- At most one of `c0`..`c6` is high in any cycle.
- States and strobes:
  - IDLE: no strobes.
  - LOAD_M: `c0`; the host presents the multiplicand on ibus.
  - LOAD_Q: `c1`; the host presents the multiplier on ibus.
  - TEST: no strobes; decodes {q0,q_m1}.
  - ADD: `c2`.
  - SUB: `c3`.
  - SHIFT: `c4`.
  - OUT_A: `c5`.
  - OUT_Q: `c6`.
  - DONE: `done`.
- Transitions:
  - IDLE → LOAD_M when `start`=1.
  - LOAD_M → LOAD_Q → TEST.
  - TEST: {q0,q_m1}=01 → ADD; 10 → SUB; 00 or 11 → SHIFT.
  - ADD → SHIFT; SUB → SHIFT.
  - SHIFT → OUT_A if cnt == N−1, else TEST.
  - OUT_A → OUT_Q → DONE → IDLE.
- Counter `cnt` (CW bits):
  - Cleared in LOAD_M.
  - Incremented in SHIFT.
  - Exactly N SHIFT states per operation; cnt wraps to 0 on the last SHIFT and is never compared beyond N−1.
- `start` is ignored while busy. A `start` held high through DONE begins a new operation from IDLE on the following edge.
- `q0`/`q_m1` are sampled only at the TEST→next edge. They are not sampled during ADD, SUB or SHIFT.

## Timing
- Reset (async, any state): state=IDLE, cnt=0, `c0`..`c6`=0, `busy`=0, `done`=0. This takes effect immediately, without waiting for a clock edge. After release, the FSM waits for a new `start`. A reset mid-operation abandons the operation with no further strobes.
- `start` high at edge k → LOAD_M during cycle k+1 (`c0` high).
- Iteration cost: 2 cycles for pair 00/11; 3 cycles for pair 01/10.
- Total busy cycles = 2 + Σ(iteration costs) + 3. This ranges from 2N+5 (21 for N=8) to 3N+5 (29 for N=8).
- `done` is high for exactly one cycle, the cycle after `c6`. `busy` drops in the following cycle.

## Structure
- Shared package `booth_pkg` holds:
  - the state enum (IDLE, LOAD_M, LOAD_Q, TEST, ADD, SUB, SHIFT, OUT_A, OUT_Q, DONE);
  - the default N;
  - the strobe index constants C_LOADM..C_OUTQ.
- Sub-module `booth_iter_cnt` (CW-bit counter with clear, inc and `last` = cnt==N−1) is instantiated once. The remainder is a single FSM with registered state and a combinational next-state/output decode.

## Test plan
- Multiplier 8'h00 (q0,q_m1 always 00): 8× `c4`, zero `c2`/`c3`, `done` 21 cycles after LOAD_M start, `busy` high 21 cycles.
- Multiplier 8'h01: TEST pairs 10,01,00×6 give the strobe order `c3`,`c4`,`c2`,`c4`, then 6×`c4`; busy 23 cycles.
- Multiplier 8'h55: alternating SUB/ADD, 4×`c3`, 4×`c2`, 8×`c4`; busy 29 cycles; `c5` then `c6` then `done` on consecutive cycles.
- Multiplier 8'hFF: one `c3` in iteration 1, then 7 pairs of 11 with shifts only; busy 22 cycles.
- `rst_b` asserted during the 4th SHIFT: all strobes drop immediately, state=IDLE. After release, no strobes until `start`. A new `start` runs a full 21–29 cycle sequence.
- `start` pulsed during TEST and held high through DONE: the mid-operation pulse has no effect. The next LOAD_M begins exactly one cycle after IDLE is re-entered. At most one strobe is high in any cycle (checked every cycle).
